// File: rtl/decode_stage.sv
// RV32I decode stage: one pipeline register holding the decoded fields of the accepted instruction,
// plus a RUN/DRAIN/DONE tracker that reports when every fetched instruction has left the stage.
module decode_stage #(
   parameter int COUNT_W = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   input  logic [31:0]        in_instr,
   input  logic [31:0]        in_pc,
   input  logic               fetch_complete,
   input  logic               flush,
   input  logic               out_ready,
   output logic               in_ready,
   output logic               out_valid,
   output logic [31:0]        out_pc,
   output logic [6:0]         opcode,
   output logic [4:0]         rd,
   output logic [4:0]         rs1,
   output logic [4:0]         rs2,
   output logic [2:0]         funct3,
   output logic [6:0]         funct7,
   output logic [31:0]        imm,
   output logic               illegal,
   output logic               decode_complete,
   output logic [COUNT_W-1:0] decoded_count,
   output logic [1:0]         dbg_state_o
);

   // Handshakes: a transfer happens on a cycle where valid && ready at the rising edge;
   // out_valid and the held fields never change while out_valid && !out_ready, except on flush/reset.
   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             state_q;
   logic               out_valid_q;
   logic               done_q;
   logic [31:0]        pc_q;
   logic [6:0]         opcode_q;
   logic [4:0]         rd_q;
   logic [4:0]         rs1_q;
   logic [4:0]         rs2_q;
   logic [2:0]         funct3_q;
   logic [6:0]         funct7_q;
   logic [31:0]        imm_q;
   logic               illegal_q;
   logic [COUNT_W-1:0] count_q;

   logic               accept;
   logic               out_hs;
   logic               valid_d;
   logic [31:0]        dec_imm;
   logic               dec_illegal;

   assign in_ready = (state_q == RUN) && !flush && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;
   assign out_hs   = out_valid_q && out_ready;

   always_comb begin
      valid_d = out_valid_q;
      if (flush)       valid_d = 1'b0;
      else if (accept) valid_d = 1'b1;
      else if (out_hs) valid_d = 1'b0;
   end

   always_comb begin
      dec_imm     = 32'd0;
      dec_illegal = 1'b0;
      case (in_instr[6:0])
         7'b0110111, 7'b0010111: dec_imm = {in_instr[31:12], 12'd0};
         7'b1101111: dec_imm = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                                in_instr[20], in_instr[30:21], 1'b0};
         7'b1100111, 7'b0000011, 7'b0010011: dec_imm = {{20{in_instr[31]}}, in_instr[31:20]};
         7'b0100011: dec_imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
         7'b1100011: dec_imm = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                                in_instr[30:25], in_instr[11:8], 1'b0};
         7'b0110011: dec_imm = 32'd0;
         default:    dec_illegal = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= RUN;
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
         pc_q        <= 32'd0;
         opcode_q    <= 7'd0;
         rd_q        <= 5'd0;
         rs1_q       <= 5'd0;
         rs2_q       <= 5'd0;
         funct3_q    <= 3'd0;
         funct7_q    <= 7'd0;
         imm_q       <= 32'd0;
         illegal_q   <= 1'b0;
         count_q     <= '0;
      end else begin
         out_valid_q <= valid_d;
         if (accept) begin
            pc_q      <= in_pc;
            opcode_q  <= in_instr[6:0];
            rd_q      <= in_instr[11:7];
            rs1_q     <= in_instr[19:15];
            rs2_q     <= in_instr[24:20];
            funct3_q  <= in_instr[14:12];
            funct7_q  <= in_instr[31:25];
            imm_q     <= dec_imm;
            illegal_q <= dec_illegal;
         end
         // A handshake coinciding with flush is discarded, so it is not counted.
         if (out_hs && !flush) count_q <= count_q + COUNT_W'(1);
         case (state_q)
            RUN:   if (fetch_complete) state_q <= DRAIN;
            DRAIN: if (!valid_d) begin
                      state_q <= DONE;
                      done_q  <= 1'b1;
                   end
            DONE:  state_q <= DONE;
            default: state_q <= RUN;
         endcase
      end
   end

   assign out_valid       = out_valid_q;
   assign out_pc          = pc_q;
   assign opcode          = opcode_q;
   assign rd              = rd_q;
   assign rs1             = rs1_q;
   assign rs2             = rs2_q;
   assign funct3          = funct3_q;
   assign funct7          = funct7_q;
   assign imm             = imm_q;
   assign illegal         = illegal_q;
   assign decode_complete = done_q;
   assign decoded_count   = count_q;
   assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed vectors, a spec-level model compared every cycle,
// a PC scoreboard on output handshakes and hand-computed literal checks.
module tb_decode_stage;

   localparam int CW = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic [31:0]   in_instr;
   logic [31:0]   in_pc;
   logic          fetch_complete;
   logic          flush;
   logic          out_ready;
   logic          in_ready;
   logic          out_valid;
   logic [31:0]   out_pc;
   logic [6:0]    opcode;
   logic [4:0]    rd, rs1, rs2;
   logic [2:0]    funct3;
   logic [6:0]    funct7;
   logic [31:0]   imm;
   logic          illegal;
   logic          decode_complete;
   logic [CW-1:0] decoded_count;
   logic [1:0]    dbg_state;

   decode_stage #(.COUNT_W(CW)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
      .fetch_complete(fetch_complete), .flush(flush), .out_ready(out_ready),
      .in_ready(in_ready), .out_valid(out_valid), .out_pc(out_pc), .opcode(opcode),
      .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7), .imm(imm),
      .illegal(illegal), .decode_complete(decode_complete), .decoded_count(decoded_count),
      .dbg_state_o(dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: run did not reach its summary");
      $fatal(1);
   end

   int passed = 0;
   int total  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // behavioural model
   typedef struct packed {
      logic [31:0] pc;
      logic [6:0]  opc;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] imm;
      logic        ill;
   } fld_t;

   function automatic logic [31:0] sx(input logic [31:0] v, input int n);
      logic [31:0] top;
      top = 32'd1 << n;
      return v[n-1] ? v - top : v;
   endfunction

   function automatic fld_t ref_decode(input logic [31:0] i, input logic [31:0] pc);
      fld_t f;
      f.pc = pc; f.opc = i[6:0]; f.rd = i[11:7]; f.rs1 = i[19:15]; f.rs2 = i[24:20];
      f.f3 = i[14:12]; f.f7 = i[31:25]; f.ill = 1'b0; f.imm = 32'd0;
      case (i[6:0])
         7'h37, 7'h17:        f.imm = i & 32'hFFFF_F000;
         7'h6F:               f.imm = sx({11'd0, i[31], i[19:12], i[20], i[30:21], 1'b0}, 21);
         7'h67, 7'h03, 7'h13: f.imm = sx({20'd0, i[31:20]}, 12);
         7'h23:               f.imm = sx({20'd0, i[31:25], i[11:7]}, 12);
         7'h63:               f.imm = sx({19'd0, i[31], i[7], i[30:25], i[11:8], 1'b0}, 13);
         7'h33:               f.imm = 32'd0;
         default:             f.ill = 1'b1;
      endcase
      return f;
   endfunction

   logic          m_valid;
   fld_t          m_f;
   logic [CW-1:0] m_count;
   int            m_phase;  // 0 running, 1 draining, 2 done
   logic          m_in_ready, m_acc, m_hs, m_nv;

   always_comb begin
      m_in_ready = (m_phase == 0) && !flush && (!m_valid || out_ready);
      m_acc      = in_valid && m_in_ready;
      m_hs       = m_valid && out_ready;
      m_nv       = flush ? 1'b0 : (m_acc ? 1'b1 : (m_hs ? 1'b0 : m_valid));
   end

   always @(posedge clk) begin
      if (reset) begin
         m_valid <= 1'b0;
         m_f     <= '0;
         m_count <= '0;
         m_phase <= 0;
      end else begin
         m_valid <= m_nv;
         if (m_acc) m_f <= ref_decode(in_instr, in_pc);
         if (m_hs && !flush) m_count <= m_count + 1'b1;
         if (m_phase == 0 && fetch_complete) m_phase <= 1;
         else if (m_phase == 1 && !m_nv) m_phase <= 2;
      end
   end

   // scoreboard + per-cycle compare
   logic [31:0] exp_q[$];

   always @(negedge clk) begin
      if (reset) begin
         exp_q.delete();
      end else begin
         check("out_valid", out_valid, m_valid);
         check("in_ready", in_ready, m_in_ready);
         check("decode_complete", decode_complete, m_phase == 2);
         check("decoded_count", decoded_count, m_count);
         if (m_valid) begin
            check("out_pc", out_pc, m_f.pc);
            check("imm", imm, m_f.imm);
            check("fields", {opcode, rd, rs1, rs2, funct3, funct7, illegal},
                  {m_f.opc, m_f.rd, m_f.rs1, m_f.rs2, m_f.f3, m_f.f7, m_f.ill});
         end
         if (flush) begin
            exp_q.delete();
         end else begin
            if (m_hs) begin
               if (exp_q.size() == 0) check("sb_nonempty", 1'b0, 1'b1);
               else check("sb_out_pc", out_pc, exp_q.pop_front());
            end
            if (m_acc) exp_q.push_back(in_pc);
         end
      end
   end

   // driver
   task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic fc, input logic fl, input logic ordy);
      in_valid = v; in_instr = ins; in_pc = pc;
      fetch_complete = fc; flush = fl; out_ready = ordy;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic ordy);
      cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, ordy);
   endtask

   logic [31:0] tbl_instr [6] = '{32'h008000EF, 32'h0020A223, 32'h00001097,
                                  32'h002081B3, 32'h000080E7, 32'hFFC0A103};

   initial begin
      reset = 1'b1;
      idle(1'b0);
      idle(1'b0);
      reset = 1'b0;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_count", decoded_count, 0);
      check("rst_out_pc", out_pc, 32'd0);
      check("rst_fields", {opcode, rd, rs1, rs2, funct3, funct7, illegal, imm}, 0);
      check("rst_decode_complete", decode_complete, 1'b0);
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; fetch_complete = 1'b0;
      #1;
      check("rst_in_ready", in_ready, 1'b1);

      cyc(1'b1, 32'h00500093, 32'h0, 1'b0, 1'b0, 1'b1);
      check("addi_valid", out_valid, 1'b1);
      check("addi_opcode", opcode, 7'h13);
      check("addi_rd_rs1_f3", {rd, rs1, funct3}, {5'd1, 5'd0, 3'd0});
      check("addi_imm", imm, 32'h5);
      check("addi_illegal", illegal, 1'b0);
      idle(1'b1);
      check("addi_count", decoded_count, 1);

      cyc(1'b1, 32'hFE208EE3, 32'h10, 1'b0, 1'b0, 1'b1);
      check("beq_rs", {rs1, rs2}, {5'd1, 5'd2});
      check("beq_imm", imm, 32'hFFFF_FFFC);
      cyc(1'b1, 32'h123452B7, 32'h14, 1'b0, 1'b0, 1'b1);
      check("lui_rd", rd, 5'd5);
      check("lui_imm", imm, 32'h1234_5000);
      check("lui_count", decoded_count, 2);
      idle(1'b1);
      check("lui_count_after", decoded_count, 3);

      cyc(1'b1, 32'h00A00113, 32'h20, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) begin
         cyc(1'b1, 32'h00B00193, 32'h24, 1'b0, 1'b0, 1'b0);
         check("stall_in_ready", in_ready, 1'b0);
         check("stall_out_pc", out_pc, 32'h20);
         check("stall_count", decoded_count, 3);
      end
      cyc(1'b1, 32'h00B00193, 32'h24, 1'b0, 1'b0, 1'b1);
      check("release_pc", out_pc, 32'h24);
      check("release_count", decoded_count, 4);
      cyc(1'b1, 32'h00C00213, 32'h28, 1'b0, 1'b0, 1'b1);
      check("b2b_count", decoded_count, 5);
      idle(1'b1);
      check("b2b_count_after", decoded_count, 6);

      cyc(1'b1, 32'h00000000, 32'h30, 1'b0, 1'b0, 1'b0);
      check("zero_illegal", illegal, 1'b1);
      check("zero_imm", imm, 32'd0);
      check("zero_valid", out_valid, 1'b1);

      cyc(1'b1, 32'h00D00293, 32'h34, 1'b0, 1'b1, 1'b0);
      check("flush_valid", out_valid, 1'b0);
      check("flush_count", decoded_count, 6);
      check("flush_not_taken", out_pc, 32'h30);
      idle(1'b1);
      check("flush_idle_valid", out_valid, 1'b0);

      for (int k = 0; k < 6; k++)
         cyc(1'b1, tbl_instr[k], 32'h100 + 32'(4 * k), 1'b0, 1'b0, 1'b1);
      idle(1'b1);

      cyc(1'b1, 32'h00100313, 32'h40, 1'b1, 1'b0, 1'b0);
      check("fc_accept_valid", out_valid, 1'b1);
      check("fc_accept_pc", out_pc, 32'h40);
      check("fc_not_done", decode_complete, 1'b0);
      cyc(1'b1, 32'h00200393, 32'h44, 1'b1, 1'b0, 1'b0);
      check("drain_in_ready", in_ready, 1'b0);
      check("drain_not_done", decode_complete, 1'b0);
      check("drain_held_pc", out_pc, 32'h40);
      cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
      check("done_set", decode_complete, 1'b1);
      check("done_valid", out_valid, 1'b0);
      cyc(1'b1, 32'h00500093, 32'h48, 1'b0, 1'b1, 1'b1);
      check("done_sticky_flush", decode_complete, 1'b1);
      cyc(1'b1, 32'h00500093, 32'h4C, 1'b0, 1'b0, 1'b1);
      check("done_sticky", decode_complete, 1'b1);
      check("done_no_accept", out_valid, 1'b0);

      reset = 1'b1;
      cyc(1'b1, 32'h00500093, 32'h50, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      check("rst2_count", decoded_count, 0);
      check("rst2_done", decode_complete, 1'b0);
      check("rst2_valid", out_valid, 1'b0);
      in_valid = 1'b0;
      #1;
      check("rst2_in_ready", in_ready, 1'b1);
      cyc(1'b1, 32'h00500093, 32'h50, 1'b0, 1'b0, 1'b1);
      check("rst2_pc", out_pc, 32'h50);
      idle(1'b1);
      check("rst2_count_after", decoded_count, 1);

      @(negedge clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter: COUNT_W, default 32, width of the decoded-instruction counter.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  fetch side presents an instruction this cycle.
REQ-005 in_instr  input  32  RV32I instruction word from fetch.
REQ-006 in_pc  input  32  byte address of in_instr.
REQ-007 fetch_complete  input  1  fetch has no further instructions; level, sampled each cycle.
REQ-008 flush  input  1  discard held and incoming instruction this cycle.
REQ-009 out_ready  input  1  downstream can accept the output this cycle.
REQ-010 in_ready  output  1  stage can accept an instruction this cycle.
REQ-011 out_valid  output  1  decoded fields below are valid.
REQ-012 out_pc  output  32  PC of held instruction.
REQ-013 opcode  output  7  instr[6:0].
REQ-014 rd, rs1, rs2  output  5 each  instr[11:7], [19:15], [24:20].
REQ-015 funct3  output  3  instr[14:12]; funct7  output  7  instr[31:25].
REQ-016 imm  output  32  sign-extended immediate per format.
REQ-017 illegal  output  1  opcode not in the supported set.
REQ-018 decode_complete  output  1  all fetched instructions have left the stage.
REQ-019 decoded_count  output  COUNT_W  number of output handshakes since reset.

Function
REQ-020 Single pipeline register; decode fields computed from in_instr and registered on accept; latency exactly 1 cycle from accept to out_valid=1.
REQ-021 Accept = in_valid && in_ready; output handshake = out_valid && out_ready.
REQ-022 in_ready = (state==RUN) && !flush && (!out_valid || out_ready); combinational from registered state and inputs.
REQ-023 Held outputs SHALL stay stable while out_valid && !out_ready.
REQ-024 Next out_valid: 0 if flush; else 1 on accept; else 0 on output handshake; else unchanged.
REQ-025 Simultaneous output handshake and accept SHALL replace the register with the new instruction, no bubble.
REQ-026 Supported opcodes: 0110111 LUI, 0010111 AUIPC (U); 1101111 JAL (J); 1100111 JALR, 0000011 LOAD, 0010011 OP-IMM (I); 0100011 STORE (S); 1100011 BRANCH (B); 0110011 OP (R, imm=0).
REQ-027 imm: I = sext(instr[31:20]); S = sext({[31:25],[11:7]}); B = sext({[31],[7],[30:25],[11:8],0}); U = {[31:12],12'b0}; J = sext({[31],[19:12],[20],[30:21],0}).
REQ-028 Unsupported opcode: illegal=1, imm=0, other fields still extracted, instruction passed downstream normally.
REQ-029 decoded_count increments by 1 on each output handshake; wraps modulo 2^COUNT_W.
REQ-030 State machine RUN, DRAIN, DONE; RUN -> DRAIN when fetch_complete=1 (accept in that same cycle still honoured).
REQ-031 DRAIN: in_ready=0; DRAIN -> DONE when next out_valid will be 0 (empty, handshaking, or flush).
REQ-032 DONE: decode_complete=1, in_ready=0, out_valid=0; sticky until reset; flush has no further effect.
REQ-033 decode_complete=1 only in DONE.
REQ-034 Flush in any state: clears out_valid next cycle, incoming instruction dropped, decoded_count unchanged, state transitions still evaluated.

Reset
REQ-035 While reset=1 at posedge: state=RUN, out_valid=0, decode_complete=0, decoded_count=0, out_pc=0, all decode fields and illegal=0.
REQ-036 Reset mid-operation SHALL discard any held instruction; in_ready=1 in the first cycle after reset deasserts (given flush=0).

Verification
REQ-037 Accept 0x00500093, pc=0x0, out_ready=1 -> next cycle out_valid=1, opcode=0x13, rd=1, rs1=0, funct3=0, imm=0x5, illegal=0, decoded_count=1 one cycle later.
REQ-038 Accept 0xFE208EE3 (beq x1,x2,-4) -> rs1=1, rs2=2, imm=0xFFFFFFFC; accept 0x123452B7 -> rd=5, imm=0x12345000.
REQ-039 Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs unchanged, count unchanged; release -> back-to-back transfers, count +1 per cycle.
REQ-040 Accept 0x00000000 -> illegal=1, imm=0, out_valid=1.
REQ-041 Held valid instruction, assert flush with in_valid=1 -> next cycle out_valid=0, count unchanged, flushed input not presented.
REQ-042 fetch_complete=1 with held instruction and out_ready=0 -> in_ready=0, decode_complete=0; out_ready=1 -> decode_complete=1 next cycle, stays 1 until reset.
